// File: rtl/rob_retire.sv
// In-order reorder-buffer retirement: allocate, complete by ROB number, retire from head.
// Ports: alloc_* in / alloc_ready,alloc_rob out; complete_* in; commit_*/free_* registered out; full/empty. Optional ROB_FLUSH_EN adds flush.
module rob_retire #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_W     = 4,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              alloc_valid,
  input  logic [AREG_W-1:0] alloc_dr,
  input  logic [PREG_W-1:0] alloc_dr_p,
  input  logic [PREG_W-1:0] alloc_old_p,
  input  logic              alloc_regwrite,
  output logic              alloc_ready,
  output logic [ROB_W-1:0]  alloc_rob,
  input  logic              complete_valid,
  input  logic [ROB_W-1:0]  complete_rob,
  input  logic [DATA_W-1:0] complete_value,
  output logic              commit_valid,
  output logic [AREG_W-1:0] commit_areg,
  output logic [PREG_W-1:0] commit_preg,
  output logic [DATA_W-1:0] commit_value,
  output logic              commit_regwrite,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              full,
  output logic              empty
);

  localparam logic [ROB_W:0] CNT_FULL = (ROB_W+1)'(ROB_DEPTH);

  logic [ROB_W-1:0]     head_q, head_d;
  logic [ROB_W-1:0]     tail_q, tail_d;
  logic [ROB_W:0]       count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [AREG_W-1:0]    areg_q [ROB_DEPTH];
  logic [AREG_W-1:0]    areg_d [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_q [ROB_DEPTH];
  logic [PREG_W-1:0]    preg_d [ROB_DEPTH];
  logic [PREG_W-1:0]    oldp_q [ROB_DEPTH];
  logic [PREG_W-1:0]    oldp_d [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rw_q, rw_d;
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];
  logic [DATA_W-1:0]    value_d [ROB_DEPTH];

  logic              cv_q, cv_d;
  logic [AREG_W-1:0] careg_q, careg_d;
  logic [PREG_W-1:0] cpreg_q, cpreg_d;
  logic [DATA_W-1:0] cval_q, cval_d;
  logic              crw_q, crw_d;
  logic              fv_q, fv_d;
  logic [PREG_W-1:0] fp_q, fp_d;

  logic flush_i;
  logic acc;
  logic cmp;
  logic ret;

`ifdef ROB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign full        = (count_q == CNT_FULL);
  assign empty       = (count_q == '0);
  assign alloc_ready = !full;
  assign alloc_rob   = tail_q;

  // All three actions use pre-edge state; a flush discards them.
  assign acc = alloc_valid && !full && !flush_i;
  assign cmp = complete_valid && busy_q[complete_rob] && !flush_i;
  assign ret = busy_q[head_q] && done_q[head_q] && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    areg_d  = areg_q;
    preg_d  = preg_q;
    oldp_d  = oldp_q;
    rw_d    = rw_q;
    value_d = value_q;
    cv_d    = 1'b0;
    careg_d = careg_q;
    cpreg_d = cpreg_q;
    cval_d  = cval_q;
    crw_d   = crw_q;
    fv_d    = 1'b0;
    fp_d    = fp_q;

    if (acc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      areg_d[tail_q] = alloc_dr;
      preg_d[tail_q] = alloc_dr_p;
      oldp_d[tail_q] = alloc_old_p;
      rw_d[tail_q]   = alloc_regwrite;
      tail_d         = tail_q + 1'b1;
    end

    if (cmp) begin
      done_d[complete_rob]  = 1'b1;
      value_d[complete_rob] = complete_value;
    end

    // Retire clears after complete so a late duplicate cannot revive it.
    if (ret) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      cv_d    = 1'b1;
      careg_d = areg_q[head_q];
      cpreg_d = preg_q[head_q];
      cval_d  = value_q[head_q];
      crw_d   = rw_q[head_q];
      // preg 0 is hardwired and never returns to the free list
      if (rw_q[head_q] && (oldp_q[head_q] != '0)) begin
        fv_d = 1'b1;
        fp_d = oldp_q[head_q];
      end
      head_d = head_q + 1'b1;
    end

    unique case ({acc, ret})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      busy_d  = '0;
      done_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      cv_q    <= 1'b0;
      careg_q <= '0;
      cpreg_q <= '0;
      cval_q  <= '0;
      crw_q   <= 1'b0;
      fv_q    <= 1'b0;
      fp_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cv_q    <= cv_d;
      careg_q <= careg_d;
      cpreg_q <= cpreg_d;
      cval_q  <= cval_d;
      crw_q   <= crw_d;
      fv_q    <= fv_d;
      fp_q    <= fp_d;
    end
  end

  // Payload storage is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    areg_q  <= areg_d;
    preg_q  <= preg_d;
    oldp_q  <= oldp_d;
    rw_q    <= rw_d;
    value_q <= value_d;
  end

  assign commit_valid    = cv_q;
  assign commit_areg     = careg_q;
  assign commit_preg     = cpreg_q;
  assign commit_value    = cval_q;
  assign commit_regwrite = crw_q;
  assign free_valid      = fv_q;
  assign free_preg       = fp_q;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: vector table plus
// hand sequences for full/wrap and (with ROB_FLUSH_EN) flush.
module tb_rob_retire;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_dr;
  logic [5:0]  alloc_dr_p;
  logic [5:0]  alloc_old_p;
  logic        alloc_regwrite;
  logic        alloc_ready;
  logic [3:0]  alloc_rob;
  logic        complete_valid;
  logic [3:0]  complete_rob;
  logic [31:0] complete_value;
  logic        commit_valid;
  logic [4:0]  commit_areg;
  logic [5:0]  commit_preg;
  logic [31:0] commit_value;
  logic        commit_regwrite;
  logic        free_valid;
  logic [5:0]  free_preg;
  logic        full;
  logic        empty;

  int n_pass;
  int n_total;

  rob_retire dut (
    .clk(clk),
    .rstn(rstn),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_valid(alloc_valid),
    .alloc_dr(alloc_dr),
    .alloc_dr_p(alloc_dr_p),
    .alloc_old_p(alloc_old_p),
    .alloc_regwrite(alloc_regwrite),
    .alloc_ready(alloc_ready),
    .alloc_rob(alloc_rob),
    .complete_valid(complete_valid),
    .complete_rob(complete_rob),
    .complete_value(complete_value),
    .commit_valid(commit_valid),
    .commit_areg(commit_areg),
    .commit_preg(commit_preg),
    .commit_value(commit_value),
    .commit_regwrite(commit_regwrite),
    .free_valid(free_valid),
    .free_preg(free_preg),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        av;
    logic [4:0]  dr;
    logic [5:0]  drp;
    logic [5:0]  oldp;
    logic        rw;
    logic        cv;
    logic [3:0]  crob;
    logic [31:0] cval;
    logic        ecv;
    logic [4:0]  eareg;
    logic [5:0]  epreg;
    logic [31:0] eval;
    logic        erw;
    logic        efv;
    logic [5:0]  efp;
    logic        eempty;
    logic        efull;
    logic [3:0]  erob;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic av, logic [4:0] dr, logic [5:0] drp,
    logic [5:0] oldp, logic rw, logic cv, logic [3:0] crob,
    logic [31:0] cval, logic ecv, logic [4:0] eareg,
    logic [5:0] epreg, logic [31:0] eval, logic erw,
    logic efv, logic [5:0] efp, logic eempty, logic efull,
    logic [3:0] erob);
    vec_t v;
    v.rstn = r;     v.av = av;       v.dr = dr;
    v.drp = drp;    v.oldp = oldp;   v.rw = rw;
    v.cv = cv;      v.crob = crob;   v.cval = cval;
    v.ecv = ecv;    v.eareg = eareg; v.epreg = epreg;
    v.eval = eval;  v.erw = erw;     v.efv = efv;
    v.efp = efp;    v.eempty = eempty;
    v.efull = efull; v.erob = erob;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive(logic r, logic av, logic [4:0] dr,
                       logic [5:0] drp, logic [5:0] oldp,
                       logic rw, logic cv, logic [3:0] crob,
                       logic [31:0] cval);
    rstn           = r;
    flush          = 1'b0;
    alloc_valid    = av;
    alloc_dr       = dr;
    alloc_dr_p     = drp;
    alloc_old_p    = oldp;
    alloc_regwrite = rw;
    complete_valid = cv;
    complete_rob   = crob;
    complete_value = cval;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(string nm, logic e_cv, logic e_fv,
                           logic e_empty, logic e_full,
                           logic [3:0] e_rob);
    chk({nm, ".cv"}, 32'(commit_valid), 32'(e_cv));
    chk({nm, ".fv"}, 32'(free_valid), 32'(e_fv));
    chk({nm, ".empty"}, 32'(empty), 32'(e_empty));
    chk({nm, ".full"}, 32'(full), 32'(e_full));
    chk({nm, ".ready"}, 32'(alloc_ready), 32'(!e_full));
    chk({nm, ".rob"}, 32'(alloc_rob), 32'(e_rob));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // single alloc -> complete -> commit with free
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,1,5,33,5,1,0,0,0, 0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,32'hDEADBEEF, 0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,5,33,32'hDEADBEEF,1,1,5,1,0,1));
    // out-of-order completion, in-order retire, old_p=0 no free
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,0));
    tbl.push_back(mk(1,1,1,40,1,1,0,0,0, 0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(1,1,2,41,2,1,0,0,0, 0,0,0,0,0,0,0,0,0,2));
    tbl.push_back(mk(1,1,3,42,0,1,0,0,0, 0,0,0,0,0,0,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,1,2,32'h22, 0,0,0,0,0,0,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,1,1,32'h11, 0,0,0,0,0,0,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,32'h10, 0,0,0,0,0,0,0,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,1,40,32'h10,1,1,1,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,2,41,32'h11,1,1,2,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,3,42,32'h22,1,0,0,1,0,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0,3));
    // store (regwrite=0): commit without free
    tbl.push_back(mk(1,1,7,50,9,0,0,0,0, 0,0,0,0,0,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0,0,1,3,32'h55, 0,0,0,0,0,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 1,7,50,32'h55,0,0,0,1,0,4));
    // alloc and retire in the same edge: count stays at 1
    tbl.push_back(mk(1,1,10,53,11,1,0,0,0, 0,0,0,0,0,0,0,0,0,5));
    tbl.push_back(mk(1,0,0,0,0,0,1,4,32'h77, 0,0,0,0,0,0,0,0,0,5));
    tbl.push_back(mk(1,1,11,54,12,1,0,0,0, 1,10,53,32'h77,1,1,11,0,0,6));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,6));

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      drive(tbl[i].rstn, tbl[i].av, tbl[i].dr, tbl[i].drp,
            tbl[i].oldp, tbl[i].rw, tbl[i].cv, tbl[i].crob,
            tbl[i].cval);
      step();
      chk_state(nm, tbl[i].ecv, tbl[i].efv, tbl[i].eempty,
                tbl[i].efull, tbl[i].erob);
      if (tbl[i].ecv) begin
        chk({nm, ".areg"}, 32'(commit_areg), 32'(tbl[i].eareg));
        chk({nm, ".preg"}, 32'(commit_preg), 32'(tbl[i].epreg));
        chk({nm, ".val"}, commit_value, tbl[i].eval);
        chk({nm, ".rw"}, 32'(commit_regwrite), 32'(tbl[i].erw));
      end
      if (tbl[i].efv)
        chk({nm, ".fp"}, 32'(free_preg), 32'(tbl[i].efp));
    end

    // fill to full, reject 17th, retire with alloc held, then wrap
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 5'(i), 6'(i + 16), 6'(i + 32), 1, 0, 0, 0);
      step();
      if (i == 14) chk_state("fill14", 0, 0, 0, 0, 4'd15);
    end
    chk_state("full", 0, 0, 0, 1, 4'd0);
    drive(1, 1, 20, 60, 61, 1, 0, 0, 0);
    step();
    chk_state("rej17", 0, 0, 0, 1, 4'd0);
    drive(1, 1, 20, 60, 61, 1, 1, 0, 32'hAA);
    step();
    chk_state("cmp0", 0, 0, 0, 1, 4'd0);
    drive(1, 1, 20, 60, 61, 1, 0, 0, 0);
    step();
    chk_state("retfull", 1, 1, 0, 0, 4'd0);
    chk("retfull.areg", 32'(commit_areg), 32'd0);
    chk("retfull.preg", 32'(commit_preg), 32'd16);
    chk("retfull.val", commit_value, 32'hAA);
    chk("retfull.fp", 32'(free_preg), 32'd32);
    step();
    chk_state("wrap", 0, 0, 0, 1, 4'd1);

`ifdef ROB_FLUSH_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(i + 1), 6'(i + 20), 6'(i + 1), 1, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 1, 1, 32'h1);
    step();
    drive(1, 0, 0, 0, 0, 0, 1, 2, 32'h2);
    step();
    chk_state("prefl", 0, 0, 0, 0, 4'd4);
    drive(1, 1, 9, 30, 3, 1, 1, 3, 32'h3);
    flush = 1'b1;
    step();
    chk_state("flush", 0, 0, 1, 0, 4'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 32'h4);
    step();
    chk_state("postfl", 0, 0, 1, 0, 4'd0);
    drive(1, 1, 6, 31, 6, 1, 0, 0, 0);
    step();
    chk_state("flalloc", 0, 0, 0, 0, 4'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_state("flidle", 0, 0, 0, 0, 4'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
